// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus an MMIO page (LED, TX FIFO count, status, optional cycle counter).
// Optional cycle counter at MMIO index 3 is enabled by defining DMEM_CYCLE_COUNTER_EN.
module dmem_mmio_responder #(
  parameter int unsigned WORD       = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [31:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(WORD);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * WORD);
  localparam logic [PW:0] FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [5:0] {
    REG_LED    = 6'd0,
    REG_TXDATA = 6'd1,
    REG_STATUS = 6'd2,
    REG_CYCLE  = 6'd3
  } mmio_reg_e;

  logic        is_ram;
  logic        is_mmio;
  logic [5:0]  reg_idx;
  logic [AW-1:0] word_idx;

  assign is_ram   = addr < RAM_BYTES;
  assign is_mmio  = addr[31:8] == MMIO_BASE[31:8];
  assign reg_idx  = addr[7:2];
  assign word_idx = addr[2 +: AW];

  // RAM: synchronous read-before-write, no reset so it maps onto block memory
  logic [31:0] ram [WORD];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (we && is_ram) ram[word_idx] <= wdata;
    if (re && is_ram) ram_q <= ram[word_idx];
  end

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;

  assign full     = count == FIFO_FULL;
  assign empty    = count == '0;
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  assign push_req = we && is_mmio && (reg_idx == REG_TXDATA);
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = we && is_mmio && (reg_idx == REG_STATUS) && wdata[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= wdata[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // set wins over a same-cycle clear
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= '0;
    end else if (we && is_mmio && (reg_idx == REG_LED)) begin
      led <= wdata;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (we && is_mmio && (reg_idx == REG_CYCLE)) begin
      cycle_cnt <= wdata;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`endif

  logic [31:0] mmio_rd;

  always_comb begin
    mmio_rd = '0;
    if (is_mmio) begin
      case (reg_idx)
        REG_LED:    mmio_rd = led;
        REG_TXDATA: mmio_rd = 32'(count);
        REG_STATUS: mmio_rd = {29'b0, overflow, empty, full};
`ifdef DMEM_CYCLE_COUNTER_EN
        REG_CYCLE:  mmio_rd = cycle_cnt;
`endif
        default:    mmio_rd = '0;
      endcase
    end
  end

  // Source select and MMIO value captured with re; everything holds when re is low
  logic        rd_ram_q;
  logic [31:0] mmio_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ram_q <= 1'b0;
      mmio_q   <= '0;
    end else if (re) begin
      rd_ram_q <= is_ram;
      mmio_q   <= mmio_rd;
    end
  end

  assign rdata = rd_ram_q ? ram_q : mmio_q;

endmodule
